// File: rtl/i2c_byte_writer.sv
// i2c_byte_writer: shifts one NBITS-wide word onto SDA MSB-first after an
// I2C START, releases SDA for the ACK clock, samples the slave ACK and
// pulses o_done. Every SCL/SDA phase advance waits for i_tick.
module i2c_byte_writer #(
  parameter int unsigned NBITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_data,
  input  logic             i_sda_in,
  output logic             o_sda,
  output logic             o_scl,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ack
);

  localparam int unsigned CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LOW  = 3'd1,
    BIT_HIGH = 3'd2,
    BIT_END  = 3'd3,
    ACK_LOW  = 3'd4,
    ACK_HIGH = 3'd5,
    ACK_END  = 3'd6,
    DONE     = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; every bus phase except DONE waits for a tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start) state_d = BIT_LOW;
      BIT_LOW:  if (i_tick)  state_d = BIT_HIGH;
      BIT_HIGH: if (i_tick)  state_d = BIT_END;
      BIT_END:  if (i_tick)  state_d = (cnt_q == '0) ? ACK_LOW : BIT_LOW;
      ACK_LOW:  if (i_tick)  state_d = ACK_HIGH;
      ACK_HIGH: if (i_tick)  state_d = ACK_END;
      ACK_END:  if (i_tick)  state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath registers: shift register, bit counter, ACK flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // Datapath updates; shifting happens only on BIT_END exit (SCL low)
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shreg_d = i_data;
          cnt_d   = CNT_W'(NBITS - 1);
        end
      end
      BIT_END: begin
        if (i_tick && (cnt_q != '0)) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ACK_HIGH: begin
        if (i_tick) ack_d = ~i_sda_in;
      end
      default: ;
    endcase
  end

  // Bus output decode from state and shift register MSB
  always_comb begin
    o_scl  = 1'b0;
    o_sda  = 1'b0;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (state_q)
      IDLE:              o_busy = 1'b0;
      BIT_LOW, BIT_END:  o_sda  = shreg_q[NBITS-1];
      BIT_HIGH: begin
        o_scl = 1'b1;
        o_sda = shreg_q[NBITS-1];
      end
      ACK_LOW, ACK_END:  o_sda  = 1'b1;
      ACK_HIGH: begin
        o_scl = 1'b1;
        o_sda = 1'b1;
      end
      DONE:              o_done = 1'b1;
      default:           o_busy = 1'b0;
    endcase
  end

  assign o_ack = ack_q;

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Directed bench for i2c_byte_writer: table of single-byte transfers plus
// hand-written abort, back-to-back and idle-tick sequences.
module tb_i2c_byte_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic [7:0] data;
  logic       sda_in;
  logic       o_sda, o_scl, o_busy, o_done, o_ack;

  int n_checks = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  i2c_byte_writer #(.NBITS(8)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_tick   (tick),
    .i_start  (start),
    .i_data   (data),
    .i_sda_in (sda_in),
    .o_sda    (o_sda),
    .o_scl    (o_scl),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ack    (o_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         k;
    logic       sda_lvl;
    int         inject_at;
    logic [8:0] exp_bits;
    logic       exp_ack;
    int         exp_cyc;
    int         exp_low;
    int         exp_hi;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transfer: start is asserted now and accepted at the next edge (edge 0).
  // Returns observations; on abort it returns right after async reset assertion.
  task automatic xfer(input logic [7:0] d, input int k, input logic lvl,
                      input int inject_at, input int abort_at, input logic start_in_done,
                      output logic [8:0] bits, output int nb, output int cyc,
                      output logic ackd, output int busy_bad, output int lows,
                      output int his, output int glitch, output int done_t);
    int   c;
    logic pscl, psda;
    bits = '0; nb = 0; cyc = -1; ackd = 1'b0; busy_bad = 0;
    lows = 0; his = 0; glitch = 0; done_t = -1;
    sda_in = lvl;
    data   = d;
    start  = 1'b1;
    tick   = (k == 1);
    pscl   = o_scl;
    psda   = o_sda;
    step();
    start = 1'b0;
    data  = 8'($urandom);
    c = 0;
    while (c < 2000) begin
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        return;
      end
      if (o_done) begin
        cyc    = c;
        ackd   = o_ack;
        done_t = edge_cnt;
        break;
      end
      if (!o_busy) busy_bad++;
      if (!o_sda) lows++;
      if (o_scl) his++;
      if (o_scl && !pscl) begin
        bits = {bits[7:0], o_sda};
        nb++;
      end
      if (o_scl && (o_sda !== psda)) glitch++;
      pscl  = o_scl;
      psda  = o_sda;
      tick  = (((c + 1) % k) == 0);
      start = ((c + 1) == inject_at);
      if (start) data = 8'h00;
      step();
      c++;
    end
    if (cyc < 0) return;
    if (start_in_done) begin
      start = 1'b1;
      data  = 8'h00;
    end
    step();
    start = 1'b0;
    check($sformatf("post_done_busy_%02h", d), 32'(o_busy), 32'd0);
    check($sformatf("post_done_pulse_%02h", d), 32'(o_done), 32'd0);
    check($sformatf("post_done_ack_hold_%02h", d), 32'(o_ack), 32'(ackd));
  endtask

  task automatic check_xfer(input string tag, input logic [8:0] bits, input int nb,
                            input int cyc, input logic ackd, input int busy_bad,
                            input logic [8:0] eb, input logic ea, input int ec);
    check({tag, "_bits"}, 32'(bits), 32'(eb));
    check({tag, "_nbits"}, 32'(nb), 32'd9);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(ec));
    check({tag, "_ack"}, 32'(ackd), 32'(ea));
    check({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [8:0] bits;
    int         nb, cyc, busy_bad, lows, his, glitch, t1, t2;
    logic       ackd;

    // {data, tick period, sda_in, inject, SCL-high bits, ack, done cycle, SDA-low cycles, SCL-high cycles}
    vecs[0] = '{8'hA5, 1, 1'b0, -1, 9'h14B, 1'b1, 27,  12, 9};
    vecs[1] = '{8'h3C, 1, 1'b1, -1, 9'h079, 1'b0, 27,  12, 9};
    vecs[2] = '{8'hFF, 4, 1'b0, -1, 9'h1FF, 1'b1, 108, 0,  36};
    vecs[3] = '{8'hA5, 1, 1'b0, 10, 9'h14B, 1'b1, 27,  12, 9};

    rst_n = 1'b0; tick = 1'b0; start = 1'b0; data = 8'h00; sda_in = 1'b1;
    #1;
    check("reset_scl", 32'(o_scl), 32'd0);
    check("reset_sda", 32'(o_sda), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_ack", 32'(o_ack), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Ticks alone in IDLE do nothing
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_tick_busy", 32'(o_busy), 32'd0);
      check("idle_tick_scl", 32'(o_scl), 32'd0);
    end
    tick = 1'b0;

    for (int i = 0; i < 4; i++) begin
      xfer(vecs[i].data, vecs[i].k, vecs[i].sda_lvl, vecs[i].inject_at, -1, 1'b0,
           bits, nb, cyc, ackd, busy_bad, lows, his, glitch, t1);
      check_xfer($sformatf("vec%0d", i), bits, nb, cyc, ackd, busy_bad,
                 vecs[i].exp_bits, vecs[i].exp_ack, vecs[i].exp_cyc);
      check($sformatf("vec%0d_sda_low_cycles", i), 32'(lows), 32'(vecs[i].exp_low));
      check($sformatf("vec%0d_scl_high_cycles", i), 32'(his), 32'(vecs[i].exp_hi));
      check($sformatf("vec%0d_sda_change_scl_high", i), 32'(glitch), 32'd0);
    end

    // Async abort during bit 3 high phase; o_ack was 1 beforehand
    xfer(8'h5A, 1, 1'b0, -1, 10, 1'b0, bits, nb, cyc, ackd, busy_bad, lows, his, glitch, t1);
    check("abort_scl", 32'(o_scl), 32'd0);
    check("abort_sda", 32'(o_sda), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ack", 32'(o_ack), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_hold_done", 32'(o_done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    xfer(8'h81, 1, 1'b0, -1, -1, 1'b0, bits, nb, cyc, ackd, busy_bad, lows, his, glitch, t1);
    check_xfer("after_abort_81", bits, nb, cyc, ackd, busy_bad, 9'h103, 1'b1, 27);

    // Back-to-back: start held during DONE is ignored, next start in the following IDLE cycle
    xfer(8'hA5, 1, 1'b1, -1, -1, 1'b1, bits, nb, cyc, ackd, busy_bad, lows, his, glitch, t1);
    check_xfer("b2b_first", bits, nb, cyc, ackd, busy_bad, 9'h14B, 1'b0, 27);
    xfer(8'h5A, 1, 1'b0, -1, -1, 1'b0, bits, nb, cyc, ackd, busy_bad, lows, his, glitch, t2);
    check_xfer("b2b_second", bits, nb, cyc, ackd, busy_bad, 9'h0B5, 1'b1, 27);
    check("b2b_done_spacing", 32'(t2 - t1), 32'd29);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/i2c_byte_writer.md
Name: i2c_byte_writer

Overview:
Downstream neighbour of the I2C START generator. After START completes (SCL low, SDA low), this block shifts one data byte onto SDA MSB-first. It releases SDA for the ninth (ACK) clock, samples the slave's ACK, and pulses done. All SCL/SDA phase advances are paced by the shared i_tick strobe from the bus clock divider.

Parameters:
NBITS, 8, data bits per transfer. Legal range 1..16. Sets the shift register width and the bit counter range.

Ports:
i_clk      input   1      system clock, all logic on rising edge
i_rst_n    input   1      asynchronous active-low reset
i_tick     input   1      one-cycle phase-advance strobe from bus divider
i_start    input   1      request to transmit; sampled only in IDLE
i_data     input   NBITS  byte to send; captured in the same cycle i_start is accepted
i_sda_in   input   1      synchronised SDA line level, used for ACK sampling
o_sda      output  1      SDA drive; 1 = release/high, 0 = pull low
o_scl      output  1      SCL drive; 1 = release/high, 0 = pull low
o_busy     output  1      high whenever state != IDLE
o_done     output  1      one-cycle pulse when the transfer completes
o_ack      output  1      1 = slave ACKed (SDA sampled low); holds until the next ACK sample

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, shift register=0, bit counter=0, o_ack=0. While in IDLE: o_scl=0, o_sda=0, o_busy=0, o_done=0. Assertion mid-transfer aborts immediately; no completion pulse is generated.
- Outputs are decoded combinationally from state and the shift register MSB. Only state, shift register, bit counter and o_ack are registered.
- States, with outputs and exit conditions:
  - IDLE: scl=0, sda=0. Go to BIT_LOW on i_start. On entry to BIT_LOW, load shreg<=i_data and cnt<=NBITS-1.
  - BIT_LOW: scl=0, sda=shreg[MSB]. Go to BIT_HIGH on i_tick.
  - BIT_HIGH: scl=1, sda=shreg[MSB]. Go to BIT_END on i_tick.
  - BIT_END: scl=0, sda=shreg[MSB]. On i_tick:
    - if cnt==0, go to ACK_LOW;
    - else shift shreg left by 1 (fill 0), cnt<=cnt-1, go to BIT_LOW.
  - ACK_LOW: scl=0, sda=1. Go to ACK_HIGH on i_tick.
  - ACK_HIGH: scl=1, sda=1. On i_tick: o_ack<=~i_sda_in, go to ACK_END.
  - ACK_END: scl=0, sda=1. Go to DONE on i_tick.
  - DONE: scl=0, sda=0, o_done=1. Unconditionally go to IDLE next cycle.
  - Illegal encoding: go to IDLE.
- SDA changes only while SCL is low. The shift and counter update happen at BIT_END exit, never in a high phase.
- Latency: with i_tick held high, i_start accepted at edge 0 gives o_done high during cycle 3*NBITS+4 (cycle 28 for NBITS=8). With i_tick every K cycles, each non-IDLE/non-DONE state lasts K cycles.
- i_start outside IDLE, including during DONE, is ignored; i_data is not re-captured.
- i_tick in IDLE or DONE has no effect.
- i_start and i_tick in the same IDLE cycle: start is accepted; the tick is not consumed by BIT_LOW.
- o_ack updates only at the ACK_HIGH exit and is stable when o_done pulses.
- Back-to-back transfers: i_start may be asserted in the cycle after DONE (IDLE). There is no idle-gap requirement.

Test Plan:
1. Tick every cycle, i_data=8'hA5, i_sda_in=0 during ACK_HIGH -> SDA during SCL-high phases = 1,0,1,0,0,1,0,1 then 1. o_done pulses exactly once at cycle 28 with o_ack=1. o_busy high cycles 1..28.
2. i_data=8'h3C, i_sda_in held 1 -> bits 0,0,1,1,1,1,0,0 on SCL highs. o_done pulses with o_ack=0.
3. Tick every 4 cycles, i_data=8'hFF -> every SCL high lasts 4 cycles and SDA is constant 1 throughout. o_done occurs 27*4+1 cycles after start acceptance.
4. i_start pulsed with i_data=8'h00 at cycle 10 during a transfer of 8'hA5 -> transmitted bits still match 8'hA5. Exactly one o_done pulse.
5. i_rst_n low mid-way through bit 3, asynchronously -> outputs go to scl=0, sda=0, o_busy=0, o_ack=0 with no clock edge. No o_done pulse. A new start of 8'h81 then transmits correctly.
6. Back-to-back: second i_start (8'h5A) in the IDLE cycle right after DONE -> second byte is transmitted with no corruption. Two o_done pulses, 28 cycles apart plus 1.
